// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// ALU operation select and the instruction classes produced by the decoder.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_e;

  // Instructions whose second ALU operand is the immediate.
  function automatic logic uses_imm(input instr_class_e c);
    return (c == CLS_I) || (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

  function automatic logic is_mem_op(input instr_class_e c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Purely combinational classification of the 7-bit major opcode into the
// instruction classes the controller sequences.
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_e instr_class
);

  always_comb begin
    case (opcode)
      OP_R:      instr_class = CLS_R;
      OP_I:      instr_class = CLS_I;
      OP_LOAD:   instr_class = CLS_LOAD;
      OP_STORE:  instr_class = CLS_STORE;
      OP_BRANCH: instr_class = CLS_BRANCH;
      default:   instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// fetch and data-memory handshakes, an absorbing TRAP and a retire counter.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  opcode_i,
  input  logic        zero_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_i,
  output logic        IRWrite_o,
  output logic        PCWrite_o,
  output logic        PCSrc_o,
  output logic        ALUSrc_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        illegal_o,
  output logic [1:0]  ALUOp_o,
  output logic [2:0]  state_o,
  output logic [31:0] instret_o
);

  state_e       state_q;
  instr_class_e class_q;
  instr_class_e dec_class;
  logic [31:0]  instret_q;
  logic         retire;
  alu_op_e      alu_op;

  opcode_decoder u_decoder (
    .opcode      (opcode_i),
    .instr_class (dec_class)
  );

  // Retirement points: branch in EXEC, store on its data ack, everything else in WB.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    retire = 1'b0;
    case (state_q)
      ST_EXEC: retire = (class_q == CLS_BRANCH);
      ST_MEM:  retire = dmem_ack_i && (class_q == CLS_STORE);
      ST_WB:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      class_q   <= CLS_R;
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + 32'd1;
      state_q   <= start_i ? ST_FETCH : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_i) state_q <= ST_FETCH;
        ST_FETCH: if (imem_ack_i) state_q <= ST_DECODE;
        ST_DECODE: begin
          if (dec_class == CLS_ILLEGAL) begin
            state_q <= ST_TRAP;
          end else begin
            class_q <= dec_class;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC:  state_q <= is_mem_op(class_q) ? ST_MEM : ST_WB;
        // A store ack retires above, so an ack reaching here belongs to a load.
        ST_MEM:   if (dmem_ack_i) state_q <= ST_WB;
        ST_TRAP:  state_q <= ST_TRAP;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the registered state, plus the ack inputs where
  // a strobe must land in the handshake cycle itself.
  always_comb begin
    imem_req_o = 1'b0;
    IRWrite_o  = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    PCWrite_o  = 1'b0;
    PCSrc_o    = 1'b0;
    ALUSrc_o   = 1'b0;
    RegWrite_o = 1'b0;
    MemtoReg_o = 1'b0;
    illegal_o  = 1'b0;
    alu_op     = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        IRWrite_o  = imem_ack_i;
      end
      ST_EXEC: begin
        ALUSrc_o = uses_imm(class_q);
        if (is_mem_op(class_q)) begin
          alu_op = ALU_ADD;
        end else if (class_q == CLS_BRANCH) begin
          alu_op    = ALU_SUB;
          PCWrite_o = 1'b1;
          PCSrc_o   = zero_i;
        end else begin
          alu_op = ALU_FUNCT;
        end
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (class_q == CLS_STORE);
        PCWrite_o  = dmem_ack_i && (class_q == CLS_STORE);
      end
      ST_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = (class_q == CLS_LOAD);
        PCWrite_o  = 1'b1;
      end
      ST_TRAP:  illegal_o = 1'b1;
      default:  ;
    endcase
  end

  assign ALUOp_o   = alu_op;
  assign state_o   = state_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle expected
// state and strobe vectors for each instruction class, traps and resets.
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [6:0]  opcode_i;
  logic        zero_i;
  logic        imem_req_o;
  logic        imem_ack_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ack_i;
  logic        IRWrite_o;
  logic        PCWrite_o;
  logic        PCSrc_o;
  logic        ALUSrc_o;
  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic        illegal_o;
  logic [1:0]  ALUOp_o;
  logic [2:0]  state_o;
  logic [31:0] instret_o;

  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .opcode_i   (opcode_i),
    .zero_i     (zero_i),
    .imem_req_o (imem_req_o),
    .imem_ack_i (imem_ack_i),
    .dmem_req_o (dmem_req_o),
    .dmem_we_o  (dmem_we_o),
    .dmem_ack_i (dmem_ack_i),
    .IRWrite_o  (IRWrite_o),
    .PCWrite_o  (PCWrite_o),
    .PCSrc_o    (PCSrc_o),
    .ALUSrc_o   (ALUSrc_o),
    .RegWrite_o (RegWrite_o),
    .MemtoReg_o (MemtoReg_o),
    .illegal_o  (illegal_o),
    .ALUOp_o    (ALUOp_o),
    .state_o    (state_o),
    .instret_o  (instret_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Observed vector: state, ireq, irw, dreq, dwe, pcw, pcs, asrc, aluop, rw, m2r, ill
  logic [14:0] obs;
  assign obs = {state_o, imem_req_o, IRWrite_o, dmem_req_o, dmem_we_o, PCWrite_o,
                PCSrc_o, ALUSrc_o, ALUOp_o, RegWrite_o, MemtoReg_o, illegal_o};

  function automatic logic [14:0] v(input logic [2:0] st, input logic ireq, irw, dreq, dwe,
                                    pcw, pcs, asrc, input logic [1:0] aop,
                                    input logic rw, m2r, ill);
    return {st, ireq, irw, dreq, dwe, pcw, pcs, asrc, aop, rw, m2r, ill};
  endfunction

  // Advance one clock, then apply {start, imem_ack, dmem_ack, zero} and let logic settle.
  task automatic cycle(input logic [3:0] in);
    @(posedge clk_i);
    #1;
    {start_i, imem_ack_i, dmem_ack_i, zero_i} = in;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b1; opcode_i = OP_R; zero_i = 1'b0;
    imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
    #3;
    checks++;
    if (obs !== 15'd0 || instret_o !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: got %b/%h expected all zero", obs, instret_o);
    end
    cycle(4'b1000);
    cycle(4'b1000);
    checks++;
    if (state_o !== ST_IDLE) begin
      errors++; $display("FAIL reset_held_idle: got %0d expected %0d", state_o, ST_IDLE);
    end
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    cycle(4'b0000);
    cycle(4'b0000);
    checks++;
    if (obs !== 15'd0) begin
      errors++; $display("FAIL idle_no_start: got %b expected all zero", obs);
    end
  endtask

  task automatic test_r_type();
    logic [3:0]  ins [5];
    logic [14:0] ex  [5];
    ins = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    ex  = '{v(ST_FETCH,  H,H,L,L,L,L,L, ALU_ADD,   L,L,L),
            v(ST_DECODE, L,L,L,L,L,L,L, ALU_ADD,   L,L,L),
            v(ST_EXEC,   L,L,L,L,L,L,L, ALU_FUNCT, L,L,L),
            v(ST_WB,     L,L,L,L,H,L,L, ALU_ADD,   H,L,L),
            v(ST_IDLE,   L,L,L,L,L,L,L, ALU_ADD,   L,L,L)};
    opcode_i = OP_R; {start_i, imem_ack_i, dmem_ack_i, zero_i} = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      cycle(ins[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL r_type cycle %0d: got %b expected %b", i, obs, ex[i]);
      end
    end
    checks++;
    if (instret_o !== 32'd1) begin
      errors++; $display("FAIL r_type_instret: got %0d expected 1", instret_o);
    end
  endtask

  task automatic test_load_wait();
    logic [3:0]  ins [9];
    logic [14:0] ex  [9];
    ins = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0100, 4'b0100};
    ex  = '{v(ST_FETCH,  H,H,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_DECODE, L,L,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_EXEC,   L,L,L,L,L,L,H, ALU_ADD, L,L,L),
            v(ST_MEM,    L,L,H,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_MEM,    L,L,H,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_MEM,    L,L,H,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_MEM,    L,L,H,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_WB,     L,L,L,L,H,L,L, ALU_ADD, H,H,L),
            v(ST_IDLE,   L,L,L,L,L,L,L, ALU_ADD, L,L,L)};
    opcode_i = OP_LOAD; {start_i, imem_ack_i, dmem_ack_i, zero_i} = 4'b1100;
    for (int i = 0; i < 9; i++) begin
      cycle(ins[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL load_wait cycle %0d: got %b expected %b", i, obs, ex[i]);
      end
    end
    checks++;
    if (instret_o !== 32'd2) begin
      errors++; $display("FAIL load_instret: got %0d expected 2", instret_o);
    end
  endtask

  task automatic test_branch_taken();
    logic [3:0]  ins [4];
    logic [14:0] ex  [4];
    ins = '{4'b0101, 4'b0101, 4'b0101, 4'b0101};
    ex  = '{v(ST_FETCH,  H,H,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_DECODE, L,L,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_EXEC,   L,L,L,L,H,H,L, ALU_SUB, L,L,L),
            v(ST_IDLE,   L,L,L,L,L,L,L, ALU_ADD, L,L,L)};
    opcode_i = OP_BRANCH; {start_i, imem_ack_i, dmem_ack_i, zero_i} = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      cycle(ins[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL branch_taken cycle %0d: got %b expected %b", i, obs, ex[i]);
      end
    end
    checks++;
    if (instret_o !== 32'd3) begin
      errors++; $display("FAIL branch_taken_instret: got %0d expected 3", instret_o);
    end
  endtask

  // Two not-taken branches back to back: start_i held through the first retirement.
  task automatic test_back_to_back();
    logic [3:0]  ins [7];
    logic [14:0] ex  [7];
    ins = '{4'b1100, 4'b1100, 4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    ex  = '{v(ST_FETCH,  H,H,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_DECODE, L,L,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_EXEC,   L,L,L,L,H,L,L, ALU_SUB, L,L,L),
            v(ST_FETCH,  H,H,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_DECODE, L,L,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_EXEC,   L,L,L,L,H,L,L, ALU_SUB, L,L,L),
            v(ST_IDLE,   L,L,L,L,L,L,L, ALU_ADD, L,L,L)};
    opcode_i = OP_BRANCH; {start_i, imem_ack_i, dmem_ack_i, zero_i} = 4'b1100;
    for (int i = 0; i < 7; i++) begin
      cycle(ins[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL back_to_back cycle %0d: got %b expected %b", i, obs, ex[i]);
      end
    end
    checks++;
    if (instret_o !== 32'd5) begin
      errors++; $display("FAIL back_to_back_instret: got %0d expected 5", instret_o);
    end
  endtask

  task automatic test_trap();
    logic [3:0]  ins [4];
    logic [14:0] ex  [4];
    ins = '{4'b0000, 4'b0100, 4'b0100, 4'b0100};
    ex  = '{v(ST_FETCH,  H,L,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_FETCH,  H,H,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_DECODE, L,L,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_TRAP,   L,L,L,L,L,L,L, ALU_ADD, L,L,H)};
    opcode_i = 7'b1111111; {start_i, imem_ack_i, dmem_ack_i, zero_i} = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      cycle(ins[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL trap_entry cycle %0d: got %b expected %b", i, obs, ex[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      cycle(4'b1111);
      checks++;
      if (obs !== v(ST_TRAP, L,L,L,L,L,L,L, ALU_ADD, L,L,H) || instret_o !== 32'd5) begin
        errors++; $display("FAIL trap_hold cycle %0d: got %b/%0d expected trap/5", i, obs, instret_o);
      end
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (obs !== 15'd0 || instret_o !== 32'd0) begin
      errors++; $display("FAIL trap_reset: got %b/%h expected all zero", obs, instret_o);
    end
    {start_i, imem_ack_i, dmem_ack_i, zero_i} = 4'b0000;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_store_wrap();
    logic [3:0]  ins [5];
    logic [14:0] ex  [5];
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    checks++;
    if (instret_o !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL instret_preset: got %h expected ffffffff", instret_o);
    end
    ins = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    ex  = '{v(ST_FETCH,  H,H,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_DECODE, L,L,L,L,L,L,L, ALU_ADD, L,L,L),
            v(ST_EXEC,   L,L,L,L,L,L,H, ALU_ADD, L,L,L),
            v(ST_MEM,    L,L,H,H,H,L,L, ALU_ADD, L,L,L),
            v(ST_IDLE,   L,L,L,L,L,L,L, ALU_ADD, L,L,L)};
    opcode_i = OP_STORE; {start_i, imem_ack_i, dmem_ack_i, zero_i} = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      cycle(ins[i]);
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL store_wrap cycle %0d: got %b expected %b", i, obs, ex[i]);
      end
    end
    checks++;
    if (instret_o !== 32'd0) begin
      errors++; $display("FAIL instret_wrap: got %h expected 00000000", instret_o);
    end
  endtask

  task automatic test_reset_in_mem();
    opcode_i = OP_STORE; {start_i, imem_ack_i, dmem_ack_i, zero_i} = 4'b1100;
    cycle(4'b0100);
    cycle(4'b0100);
    cycle(4'b0100);
    cycle(4'b0100);
    checks++;
    if (obs !== v(ST_MEM, L,L,H,H,L,L,L, ALU_ADD, L,L,L)) begin
      errors++; $display("FAIL mem_wait: got %b expected store MEM", obs);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (dmem_req_o !== 1'b0 || obs !== 15'd0) begin
      errors++; $display("FAIL reset_in_mem: got %b expected all zero", obs);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch_taken();
    test_back_to_back();
    test_trap();
    test_store_wrap();
    test_reset_in_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock, all state on rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port start_i, input, 1: run enable, level-sensitive.
REQ-004 SHALL have port opcode_i, input, 7: instruction register bits [6:0].
REQ-005 SHALL have port zero_i, input, 1: ALU zero flag (branch compare).
REQ-006 SHALL have ports imem_req_o (output, 1) and imem_ack_i (input, 1): instruction-fetch handshake.
REQ-007 SHALL have ports dmem_req_o (output, 1), dmem_we_o (output, 1) and dmem_ack_i (input, 1): data-memory handshake; dmem_we_o is 1 for a store.
REQ-008 SHALL have output ports, 1 bit each: IRWrite_o, PCWrite_o, PCSrc_o, ALUSrc_o, RegWrite_o, MemtoReg_o, illegal_o.
REQ-009 SHALL have port ALUOp_o, output, 2: 00 add, 01 subtract, 10 funct-decoded.
REQ-010 SHALL have ports state_o (output, 3: current state encoding) and instret_o (output, 32: retired-instruction count).

Function
REQ-011 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-012 IDLE: all strobes 0; SHALL go to FETCH the cycle after start_i is sampled 1.
REQ-013 FETCH: imem_req_o=1; SHALL hold FETCH until imem_ack_i=1; in the ack cycle SHALL assert IRWrite_o=1 and go to DECODE.
REQ-014 Acks SHALL be honoured only while the matching req is 1, including in the first cycle of the state (zero-wait); acks in any other state SHALL be ignored.
REQ-015 DECODE: one cycle; legal opcodes are 0110011 (R), 0010011 (I), 0000011 (load), 0100011 (store), 1100011 (beq); any other SHALL go to TRAP; legal SHALL go to EXEC.
REQ-016 EXEC: one cycle; ALUSrc_o=1 for I/load/store, 0 for R/branch; ALUOp_o=00 for load/store, 01 for branch, 10 for R/I.
REQ-017 EXEC branch: PCWrite_o=1 and PCSrc_o=zero_i, retire; R/I go to WB; load/store go to MEM.
REQ-018 MEM: dmem_req_o=1 and dmem_we_o=1 for store, 0 for load, held until dmem_ack_i; on ack a store retires with PCWrite_o=1, and a load goes to WB.
REQ-019 WB: RegWrite_o=1, MemtoReg_o=1 for load, 0 otherwise; PCWrite_o=1 with PCSrc_o=0; retire.
REQ-020 Retire: instret_o increments by 1 and wraps 0xFFFFFFFF->0; next state is FETCH if start_i=1, else IDLE.
REQ-021 start_i falling mid-instruction SHALL NOT abort it; it is checked only at retirement and in IDLE.
REQ-022 TRAP: illegal_o=1, all strobes 0, absorbing until reset; instret_o holds.
REQ-023 Zero-wait latency SHALL be: beq 3 cycles, R/I 4, store 4, load 5.
REQ-024 Strobes SHALL be Moore or state-plus-ack decoded and glitch-free relative to clk_i; only one of PCWrite_o, RegWrite_o, IRWrite_o pulses per retirement path as specified.

Reset
REQ-025 On rst_i=0 SHALL asynchronously force IDLE, all outputs 0, instret_o=0 and illegal_o=0, including mid-handshake (req dropped immediately).
REQ-026 After rst_i is released, the first transition SHALL be on the next rising edge with start_i=1.

Structure
REQ-027 Package ctrl_pkg SHALL hold opcode constants, the state enum and the ALUOp encodings.
REQ-028 A combinational sub-module opcode_decoder SHALL classify opcode_i into R/I/load/store/branch/illegal; FSM, handshakes and counter stay in multicycle_control.

Verification
REQ-029 R-type 0110011, zero-wait acks, start_i=1 -> FETCH, DECODE, EXEC, WB, FETCH; RegWrite_o pulses once; instret_o 0->1.
REQ-030 Load 0000011 with dmem_ack_i delayed 3 cycles -> dmem_req_o high 4 cycles, dmem_we_o=0, WB has MemtoReg_o=1; total 8 cycles.
REQ-031 beq with zero_i=1 -> EXEC PCWrite_o=1, PCSrc_o=1, no RegWrite_o; with zero_i=0 -> PCSrc_o=0.
REQ-032 Opcode 1111111 -> TRAP, illegal_o=1 persists 20 cycles despite acks; rst_i low -> IDLE, illegal_o=0.
REQ-033 instret_o preset via 0xFFFFFFFF retirements (or forced), one store retirement -> 0x00000000; rst_i low during MEM -> dmem_req_o=0 same cycle.
